// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane/extension helpers for the MEM-stage access unit.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;
   typedef enum logic [0:0] {ALIGN_LOAD = 1'b0, ALIGN_MERGE = 1'b1} align_mode_t;

   // Size code 2'b11 is treated as a full word.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lane[0];
         default: mis = (lane != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sign_ext);
      return {{24{sign_ext & b[7]}}, b};
   endfunction

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sign_ext);
      return {{16{sign_ext & h[15]}}, h};
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational lane logic: extracts and extends a load value, or merges a sub-word
// store into an existing memory word, depending on mode.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0]  data,
   input  logic [15:0]  store_lo,
   input  logic [1:0]   lane,
   input  logic [1:0]   size,
   input  logic         sign_ext,
   input  align_mode_t  mode,
   output logic [31:0]  result
);

   logic [31:0] shifted;

   assign shifted = data >> {lane, 3'b000};

   // Select load extraction or store-lane merge.
   always_comb begin
      result = data;
      if (mode == ALIGN_MERGE) begin
         case (size)
            SZ_BYTE: begin
               case (lane)
                  2'b00:   result[7:0]   = store_lo[7:0];
                  2'b01:   result[15:8]  = store_lo[7:0];
                  2'b10:   result[23:16] = store_lo[7:0];
                  default: result[31:24] = store_lo[7:0];
               endcase
            end
            SZ_HALF: begin
               if (lane[1]) begin
                  result[31:16] = store_lo;
               end else begin
                  result[15:0] = store_lo;
               end
            end
            default: result = data;
         endcase
      end else begin
         case (size)
            SZ_BYTE: result = extend_byte(shifted[7:0], sign_ext);
            SZ_HALF: result = extend_half(shifted[15:0], sign_ext);
            default: result = shifted;
         endcase
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: word-index addressing, aligned loads, two-cycle sub-word
// read-modify-write stores, fault suppression and the registered MEM/WB outputs.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        memRead_in,
   input  logic        memWrite_in,
   input  logic [1:0]  size_in,
   input  logic        signExt_in,
   input  logic [31:0] aluResult_in,
   input  logic [31:0] storeData_in,
   input  logic [4:0]  rd_in,
   input  logic        regWrite_in,
   input  logic        memToReg_in,
   output logic        stall_out,
   output logic        memRead,
   output logic        memWrite,
   output logic [31:0] address,
   output logic [31:0] writeData,
   input  logic [31:0] readData,
   output logic        wb_valid,
   output logic        wb_regWrite,
   output logic        wb_memToReg,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_aluResult,
   output logic [31:0] wb_memData,
   output logic        wb_misaligned,
   output logic        wb_oob
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

   state_t      state;
   state_t      next_state;
   logic [31:0] merge_q;
   logic [1:0]  lane;
   logic        mem_req;
   logic        load_req;
   logic        store_req;
   logic        misaligned;
   logic        oob;
   logic        fault;
   align_mode_t align_mode;
   logic [31:0] align_in;
   logic [31:0] align_out;

   assign lane       = aluResult_in[1:0];
   assign address    = {2'b00, aluResult_in[31:2]};
   assign mem_req    = valid_in & (memRead_in | memWrite_in);
   assign store_req  = valid_in & memWrite_in;
   assign load_req   = valid_in & memRead_in & ~memWrite_in;
   assign misaligned = is_misaligned(size_in, lane);
   assign oob        = (address >= MEM_LIMIT);
   assign fault      = mem_req & (misaligned | oob);

   // One aligner serves both the load path (live readData) and the RMW merge (latched word).
   assign align_mode = (state == RMW_WR) ? ALIGN_MERGE : ALIGN_LOAD;
   assign align_in   = (state == RMW_WR) ? merge_q : readData;

   mem_load_align u_align (
      .data     (align_in),
      .store_lo (storeData_in[15:0]),
      .lane     (lane),
      .size     (size_in),
      .sign_ext (signExt_in),
      .mode     (align_mode),
      .result   (align_out)
   );

   // Next-state and memory strobes; reset forces all strobes low.
   always_comb begin
      next_state = state;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      stall_out  = 1'b0;
      writeData  = storeData_in;
      if (reset) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (store_req && !fault) begin
                  if (is_word(size_in)) begin
                     memWrite = 1'b1;
                  end else begin
                     memRead    = 1'b1;
                     stall_out  = 1'b1;
                     next_state = RMW_WR;
                  end
               end else if (load_req && !fault) begin
                  memRead = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
            RMW_WR: begin
               memWrite   = 1'b1;
               writeData  = align_out;
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // State, merge latch and MEM/WB register; a stall cycle inserts a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         merge_q       <= 32'h0000_0000;
         wb_valid      <= 1'b0;
         wb_regWrite   <= 1'b0;
         wb_memToReg   <= 1'b0;
         wb_rd         <= 5'd0;
         wb_aluResult  <= 32'h0000_0000;
         wb_memData    <= 32'h0000_0000;
         wb_misaligned <= 1'b0;
         wb_oob        <= 1'b0;
      end else begin
         state <= next_state;
         if (stall_out) begin
            merge_q       <= readData;
            wb_valid      <= 1'b0;
            wb_regWrite   <= 1'b0;
            wb_memToReg   <= 1'b0;
            wb_rd         <= 5'd0;
            wb_aluResult  <= 32'h0000_0000;
            wb_memData    <= 32'h0000_0000;
            wb_misaligned <= 1'b0;
            wb_oob        <= 1'b0;
         end else begin
            merge_q       <= merge_q;
            wb_valid      <= valid_in;
            wb_regWrite   <= regWrite_in & valid_in & ~fault;
            wb_memToReg   <= memToReg_in;
            wb_rd         <= rd_in;
            wb_aluResult  <= aluResult_in;
            wb_memData    <= (load_req && !fault) ? align_out : 32'h0000_0000;
            wb_misaligned <= mem_req & misaligned;
            wb_oob        <= mem_req & oob;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected MEM/WB results,
// a negedge monitor pops and compares them whenever wb_valid is presented.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in, memRead_in, memWrite_in, signExt_in, regWrite_in, memToReg_in;
   logic [1:0]  size_in;
   logic [31:0] aluResult_in, storeData_in;
   logic [4:0]  rd_in;
   logic        stall_out, memRead, memWrite;
   logic [31:0] address, writeData, readData;
   logic        wb_valid, wb_regWrite, wb_memToReg, wb_misaligned, wb_oob;
   logic [4:0]  wb_rd;
   logic [31:0] wb_aluResult, wb_memData;

   logic [31:0] mem [0:31];
   logic        pre_we;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;

   typedef struct packed {
      logic [4:0]  rd;
      logic        regwr;
      logic [31:0] alu;
      logic [31:0] data;
      logic        mis;
      logic        oob;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_WORDS(32)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .memRead_in(memRead_in),
      .memWrite_in(memWrite_in), .size_in(size_in), .signExt_in(signExt_in),
      .aluResult_in(aluResult_in), .storeData_in(storeData_in), .rd_in(rd_in),
      .regWrite_in(regWrite_in), .memToReg_in(memToReg_in), .stall_out(stall_out),
      .memRead(memRead), .memWrite(memWrite), .address(address), .writeData(writeData),
      .readData(readData), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
      .wb_memToReg(wb_memToReg), .wb_rd(wb_rd), .wb_aluResult(wb_aluResult),
      .wb_memData(wb_memData), .wb_misaligned(wb_misaligned), .wb_oob(wb_oob)
   );

   // Data memory: combinational read, write on the rising edge; preload port for setup.
   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (memWrite && address < 32'd32) mem[address[4:0]] <= writeData;
   end
   assign readData = (address < 32'd32) ? mem[address[4:0]] : 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = a; pre_data = d;
   endtask

   task automatic drive(input logic v, input logic rd_op, input logic wr_op, input logic [1:0] sz,
                        input logic sx, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic rw);
      @(posedge clk); #1;
      valid_in = v; memRead_in = rd_op; memWrite_in = wr_op; size_in = sz; signExt_in = sx;
      aluResult_in = addr; storeData_in = sdata; rd_in = rd; regWrite_in = rw; memToReg_in = rd_op;
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                           input logic [31:0] data, input logic mis, input logic oob);
      exp_t e;
      e.rd = rd; e.regwr = rw; e.alu = alu; e.data = data; e.mis = mis; e.oob = oob;
      q.push_back(e);
   endtask

   // Monitor: compare each presented writeback against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wb_valid === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d alu=%h required no writeback", wb_rd, wb_aluResult);
            end else begin
               e = q.pop_front();
               check("wb_rd",         {27'h0, wb_rd},          {27'h0, e.rd});
               check("wb_regWrite",   {31'h0, wb_regWrite},    {31'h0, e.regwr});
               check("wb_aluResult",  wb_aluResult,            e.alu);
               check("wb_memData",    wb_memData,              e.data);
               check("wb_misaligned", {31'h0, wb_misaligned},  {31'h0, e.mis});
               check("wb_oob",        {31'h0, wb_oob},         {31'h0, e.oob});
            end
         end
      end
   end

   initial begin
      reset = 1'b1; pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'h0;
      valid_in = 1'b1; memRead_in = 1'b1; memWrite_in = 1'b0; size_in = 2'b10; signExt_in = 1'b0;
      aluResult_in = 32'h0; storeData_in = 32'h0; rd_in = 5'd0; regWrite_in = 1'b1; memToReg_in = 1'b1;

      preload(5'd0, 32'h0023_00AA);
      preload(5'd1, 32'h1065_4321);
      preload(5'd3, 32'h8C12_3456);
      preload(5'd5, 32'h1122_3344);
      @(posedge clk); #1;
      pre_we = 1'b0;
      check("reset_strobes", {29'h0, memRead, memWrite, stall_out}, 32'h0);
      check("reset_wb", {27'h0, wb_valid, wb_regWrite, wb_memToReg, wb_misaligned, wb_oob}, 32'h0);
      reset = 1'b0;
      valid_in = 1'b0;

      // Byte loads, sign and zero extension, half load
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 5'd1, 1'b1);
      push_exp(5'd1, 1'b1, 32'h5, 32'h0000_0043, 1'b0, 1'b0);
      #1 check("lb_memRead", {31'h0, memRead}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 5'd2, 1'b1);
      push_exp(5'd2, 1'b1, 32'h7, 32'h0000_0010, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'hF, 32'h0, 5'd3, 1'b1);
      push_exp(5'd3, 1'b1, 32'hF, 32'hFFFF_FF8C, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hF, 32'h0, 5'd4, 1'b1);
      push_exp(5'd4, 1'b1, 32'hF, 32'h0000_008C, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 5'd5, 1'b1);
      push_exp(5'd5, 1'b1, 32'hE, 32'hFFFF_8C12, 1'b0, 1'b0);

      // Half store read-modify-write
      drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF, 5'd0, 1'b0);
      push_exp(5'd0, 1'b0, 32'h2, 32'h0, 1'b0, 1'b0);
      #1 check("sh_c1_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h6);
      @(posedge clk); #1;
      check("sh_c2_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h1);
      check("sh_writeData", writeData, 32'hBEEF_00AA);
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd6, 1'b1);
      push_exp(5'd6, 1'b1, 32'h0, 32'hBEEF_00AA, 1'b0, 1'b0);

      // Word store then load
      drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h18, 32'hDEAD_BEEF, 5'd0, 1'b0);
      push_exp(5'd0, 1'b0, 32'h18, 32'h0, 1'b0, 1'b0);
      #1 check("sw_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h1);
      check("sw_writeData", writeData, 32'hDEAD_BEEF);
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 5'd7, 1'b1);
      push_exp(5'd7, 1'b1, 32'h18, 32'hDEAD_BEEF, 1'b0, 1'b0);

      // Bubble: invalid slot must produce no strobes and no writeback
      drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1);
      #1 check("nop_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h0);

      // Faults
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 5'd8, 1'b1);
      push_exp(5'd8, 1'b0, 32'h6, 32'h0, 1'b1, 1'b0);
      #1 check("mis_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd10, 1'b1);
      push_exp(5'd10, 1'b0, 32'h80, 32'h0, 1'b0, 1'b1);
      #1 check("oob_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h0);

      // Reset during RMW_WR abandons the byte store
      drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00FF, 5'd0, 1'b0);
      #1 check("sb_c1_stall", {31'h0, stall_out}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1 check("rst_rmw_strobes", {29'h0, stall_out, memRead, memWrite}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      valid_in = 1'b0;
      check("rst_rmw_wb", {27'h0, wb_valid, wb_regWrite, wb_memToReg, wb_misaligned, wb_oob}, 32'h0);
      check("rst_rmw_wb_data", wb_memData | wb_aluResult | {27'h0, wb_rd}, 32'h0);
      check("rst_rmw_mem", mem[5], 32'h1122_3344);
      drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_5555, 5'd0, 1'b0);
      push_exp(5'd0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
      #1 check("post_rst_idle_sw", {29'h0, stall_out, memRead, memWrite}, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5'd11, 1'b1);
      push_exp(5'd11, 1'b1, 32'h14, 32'h1122_3344, 1'b0, 1'b0);

      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 check("scoreboard_drain", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage controller between the EX/MEM pipeline register and the word-addressed, combinationally-read data memory (`datamemory`); its outputs feed the MEM/WB register.
- Converts byte addresses to word indices and performs byte/half/word loads with sign or zero extension.
- Implements sub-word stores as a two-cycle read-modify-write, stalling upstream for one cycle.
- Flags misaligned and out-of-range accesses, suppresses them, and produces the registered MEM/WB outputs.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  EX/MEM slot holds a real instruction
- memRead_in  in  1  load
- memWrite_in  in  1  store; wins if memRead_in is also set
- size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- signExt_in  in  1  loads: 1 sign-extend, 0 zero-extend
- aluResult_in  in  32  byte address, or ALU result passed through
- storeData_in  in  32  store data; low bits used for sub-word stores
- rd_in  in  5  destination register
- regWrite_in  in  1  writeback enable
- memToReg_in  in  1  writeback selects memory data
- stall_out  out  1  hold EX/MEM and all earlier stages this cycle
- memRead  out  1  to datamemory
- memWrite  out  1  to datamemory
- address  out  32  word index, {2'b00, aluResult_in[31:2]}
- writeData  out  32  to datamemory
- readData  in  32  from datamemory, valid in the same cycle
- wb_valid  out  1  registered outputs to MEM/WB
- wb_regWrite  out  1
- wb_memToReg  out  1
- wb_rd  out  5
- wb_aluResult  out  32
- wb_memData  out  32
- wb_misaligned  out  1
- wb_oob  out  1

Behaviour:
- Reset: state IDLE, merge_q = 0, every wb_* output = 0. While reset is high, memRead, memWrite and stall_out are 0.
- Reset arriving during RMW_WR abandons the store; no memory write occurs.
- Lane selection: lane = aluResult_in[1:0]; byte k occupies bits [8k+7:8k] (little-endian).
- Misaligned: half with lane[0] = 1, or word with lane != 0.
- Out of range (oob): aluResult_in[31:2] >= MEM_WORDS.
- Fault = valid_in & (memRead_in | memWrite_in) & (misaligned | oob).
  - A faulting access drives no memRead or memWrite.
  - Next cycle: wb_valid = 1, wb_regWrite = 0, and the matching flag set.
- FSM states:
  - IDLE:
    - word store: memWrite = 1, writeData = storeData_in.
    - load: memRead = 1; wb_memData <= aligned and extended readData (1-cycle latency).
    - sub-word store: memRead = 1, stall_out = 1, merge_q <= readData, go to RMW_WR; wb_valid <= 0 (bubble).
    - non-memory instruction: pass through.
  - RMW_WR:
    - memWrite = 1, writeData = merge_q with the selected byte/half lane replaced by storeData_in[7:0] or [15:0].
    - stall_out = 0; wb_* outputs updated for the store; next state IDLE.
- The EX/MEM inputs are stable across both RMW cycles because stall_out holds them.
- wb register updates:
  - Every cycle with stall_out = 0: wb_valid <= valid_in, and the remaining fields are copied or computed.
  - wb_regWrite <= regWrite_in & valid_in & ~fault.
- valid_in = 0: no memory strobes; wb_valid <= 0.
- Load extension:
  - byte: {24{sign & b[7]}, b}
  - half: {16{sign & h[15]}, h}
  - word: unchanged.
- Stores never set wb_memData; it holds 0 for stores.
- memRead and memWrite are never asserted together.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD
  - FSM state enum IDLE / RMW_WR
  - lane and extension helper functions
- One combinational sub-module, mem_load_align, takes readData, lane, size and signExt and returns the aligned 32-bit load value. It is reused for store-lane merging via a mode input.

Test Plan:
- Byte load: memory word 1 = 32'h10654321, addr 32'h5, byte, signExt = 1 -> one cycle later wb_memData = 32'h00000043. Same access at addr 32'h7 -> 32'h00000010.
- Sign extension: word 3 = 32'h8C123456, addr 32'hF, byte, signExt = 1 -> 32'hFFFFFF8C; signExt = 0 -> 32'h0000008C.
- Half store RMW: word 0 = 32'h002300AA, addr 32'h2, data 32'h0000BEEF:
  - cycle 1: stall_out = 1 and memRead = 1.
  - cycle 2: memWrite = 1, writeData = 32'hBEEF00AA.
  - a following lw from 32'h0 returns 32'hBEEF00AA.
- Word store then load: store 32'hDEADBEEF to addr 32'h18 -> memWrite in 1 cycle, no stall; lw from 32'h18 returns 32'hDEADBEEF.
- Faults:
  - lw at 32'h6 -> no strobes, wb_misaligned = 1, wb_regWrite = 0.
  - lw at 32'h80 with MEM_WORDS = 32 -> wb_oob = 1.
- Reset during RMW_WR: assert reset in cycle 2 of an sb -> no memWrite, wb_* all 0, state IDLE; target word unchanged.
